// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the command dispatch scheduler.
//   CMD_HALT         opcode value that retires the command stream
//   OPCODE_MSB/LSB   opcode field position inside a 64-bit command word
//   CORE_SEL_BIT     bit selecting the target core (0=Core0, 1=Core1)
//   sched_state_t    scheduler state encoding {RUN, DRAIN, HALTED}
//   is_halt()        true when a command word carries the HALT opcode
package cmd_pkg;

    localparam logic [7:0] CMD_HALT     = 8'h00;
    localparam int         OPCODE_MSB   = 63;
    localparam int         OPCODE_LSB   = 56;
    localparam int         CORE_SEL_BIT = 48;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sched_state_t;

    function automatic logic is_halt(input logic [63:0] word);
        return word[OPCODE_MSB:OPCODE_LSB] == CMD_HALT;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst   clock and synchronous active-high reset
//   push       write wdata (ignored when full)
//   pop        drop the head entry (ignored when empty)
//   wdata      write data
//   rdata      current head entry, valid whenever !empty
//   full       DEPTH entries stored
//   empty      no entries stored
//   count      number of stored entries, 0..DEPTH
// DEPTH must be a power of two; the pointers carry one extra wrap bit so
// full and empty can be told apart when the index bits match.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer bookkeeping; each pointer advances independently so a
    // simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage has no reset; stale contents are never visible because
    // empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/cmd_dispatch_scheduler.sv
// cmd_dispatch_scheduler: in-order command queue feeding two compute cores.
//   clk, rst        clock and synchronous active-high reset
//   cmd_valid       host offers cmd_data this cycle
//   cmd_data        64-bit command; [63:56] opcode, [48] core select
//   cmd_ready       queue accepts a command this cycle
//   core0_start     one-cycle dispatch pulse to Core0
//   core1_start     one-cycle dispatch pulse to Core1
//   core_cmd        command word accompanying the start pulse, else 0
//   core0_ready     Core0 idle
//   core1_ready     Core1 idle
//   halted          HALT has retired; sticky until reset
//   occupancy       commands currently queued
//   core0_count     commands dispatched to Core0 (wrapping)
//   core1_count     commands dispatched to Core1 (wrapping)
// The queue is strictly in order: a head command waiting on a busy core
// blocks everything behind it. A HALT at the head waits until both cores
// are idle, then retires without a start pulse and freezes the scheduler.
module cmd_dispatch_scheduler #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [63:0]              cmd_data,
    output logic                     cmd_ready,
    output logic                     core0_start,
    output logic                     core1_start,
    output logic [63:0]              core_cmd,
    input  logic                     core0_ready,
    input  logic                     core1_ready,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         core0_count,
    output logic [CNT_W-1:0]         core1_count
);

    import cmd_pkg::*;

    sched_state_t state_q;
    sched_state_t state_d;

    logic        fifo_full;
    logic        fifo_empty;
    logic [63:0] head;
    logic        push;
    logic        pop;
    logic        disp0;
    logic        disp1;
    logic        halt_done;
    logic        hold0;
    logic        hold1;

    // Reset forces cmd_ready low combinationally so nothing is captured
    // in the same cycle the queue is being cleared.
    assign cmd_ready = !fifo_full && (state_q != HALTED) && !rst;
    assign push      = cmd_valid && cmd_ready;

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (cmd_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Dispatch decision. A core is eligible only when it reports ready and
    // its start is not being driven this cycle (holdoff), which covers the
    // one-cycle gap before the core has had a chance to drop ready.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        disp0     = 1'b0;
        disp1     = 1'b0;
        halt_done = 1'b0;
        case (state_q)
            RUN: begin
                if (!fifo_empty) begin
                    if (is_halt(head)) begin
                        state_d = DRAIN;
                    end else if (!head[CORE_SEL_BIT]) begin
                        if (core0_ready && !hold0) begin
                            pop   = 1'b1;
                            disp0 = 1'b1;
                        end
                    end else begin
                        if (core1_ready && !hold1) begin
                            pop   = 1'b1;
                            disp1 = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (core0_ready && core1_ready && !hold0 && !hold1) begin
                    pop       = 1'b1;
                    halt_done = 1'b1;
                    state_d   = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Registered dispatch outputs, holdoff flags, counters and halted.
    // Holdoff mirrors the start pulse: it is set exactly in the cycle the
    // core sees start.
    always_ff @(posedge clk) begin
        if (rst) begin
            core0_start <= 1'b0;
            core1_start <= 1'b0;
            core_cmd    <= '0;
            hold0       <= 1'b0;
            hold1       <= 1'b0;
            core0_count <= '0;
            core1_count <= '0;
            halted      <= 1'b0;
        end else begin
            core0_start <= disp0;
            core1_start <= disp1;
            hold0       <= disp0;
            hold1       <= disp1;
            core_cmd    <= (disp0 || disp1) ? head : 64'd0;
            if (disp0) begin
                core0_count <= core0_count + CNT_W'(1);
            end
            if (disp1) begin
                core1_count <= core1_count + CNT_W'(1);
            end
            if (halt_done) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cmd_dispatch_scheduler.md
Name: cmd_dispatch_scheduler

Overview:
Buffers 64-bit host commands in an in-order queue and dispatches each to its target core (Core0/Core1) once that core is ready.
- Pulses the core's start and presents the command word to it.
- Handles HALT by draining both cores before latching halted.
- Sits between the host command link and the two compute cores.
- Exposes queue occupancy and per-core dispatch counters for debug.

Parameters:
DEPTH, 8, queue depth in commands; power of two, minimum 2.
CNT_W, 32, width of the per-core dispatch counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_data  in  64  command word; [63:56] opcode, [48] core select (0=Core0, 1=Core1)
cmd_ready  out  1  queue can accept a command this cycle
core0_start  out  1  one-cycle dispatch pulse to Core0
core1_start  out  1  one-cycle dispatch pulse to Core1
core_cmd  out  64  command word of the dispatch pulsed this cycle
core0_ready  in  1  Core0 idle
core1_ready  in  1  Core1 idle
halted  out  1  HALT retired; sticky until reset
occupancy  out  $clog2(DEPTH)+1  entries currently queued
core0_count  out  CNT_W  commands dispatched to Core0
core1_count  out  CNT_W  commands dispatched to Core1

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all outputs 0. Queue emptied; state RUN; holdoffs cleared. Reset mid-operation discards queued commands, including any queued behind a HALT.
- Accept rule:
  - cmd_ready = !full && state!=HALTED && !rst.
  - A push occurs when cmd_valid && cmd_ready.
  - When full, no push is allowed even if a pop happens in the same cycle.
  - cmd_data is captured unmodified.
- Queue: in-order, head-of-line blocking. A command blocked on a busy core also blocks commands for the other core.
- Dispatch, state RUN, head is a non-HALT command with target T:
  - Dispatch in cycle c when T's ready is high and T's holdoff is clear.
  - The head is popped in c.
  - coreT_start=1 and core_cmd=head word are registered, visible in c+1 for exactly one cycle.
  - coreT_count increments by 1 and wraps at 2^CNT_W.
- Minimum latency: command accepted in cycle n produces its start pulse in cycle n+2.
- Holdoff:
  - Core contract: the core drops ready the cycle after it sees start.
  - The scheduler sets a per-core holdoff for the cycle in which it drives that core's start, and never dispatches to that core in that cycle.
  - Result: at most one start to a given core every 2 cycles.
  - core_cmd is 0 when no start is asserted.
- States:
  - RUN: normal dispatch. A HALT (opcode 0x00) reaching the head moves the state to DRAIN with no pop, regardless of bit 48.
  - DRAIN:
    - No pops.
    - Pushes are still accepted while not full.
    - When core0_ready && core1_ready && both holdoffs clear, pop the HALT, register halted=1, go to HALTED.
    - Neither start is pulsed for the HALT.
  - HALTED: cmd_ready=0; no dispatch; halted stays 1. Only rst exits.
- Empty queue: no dispatch, no start pulses, outputs idle.
- occupancy reflects the registered count: +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- Counters never increment for HALT.

Decomposition:
- Shared package (cmd_pkg) holds:
  - CMD_HALT = 8'h00.
  - OPCODE_MSB/LSB = 63/56.
  - CORE_SEL_BIT = 48.
  - State enum {RUN, DRAIN, HALTED}.
- One sub-module, sync_fifo:
  - Parameterised WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata (show-ahead head), full, empty, count.
  - Ptr width = $clog2(DEPTH)+1.
- The scheduler contains the FSM, holdoff flags, start/core_cmd registers and counters.

Test Plan:
- Reset, then push 0x0100_0000_0000_0001 (Core0) with both cores ready → core0_start high exactly 2 cycles after acceptance for 1 cycle, core_cmd=that word, core0_count=1.
- Hold core0_ready=0; push Core0 cmd then Core1 cmd 0x0101_0000_0000_0002 → no starts (head-of-line block). Raise core0_ready → core0_start, and core1_start follows 1 cycle later (not earlier).
- Hold both readies low; push DEPTH=8 commands → cmd_ready=0, occupancy=8, a 9th valid is not accepted. Release readies → all 8 dispatched in order, counts sum to 8.
- Push Core0 cmd, HALT (0x00..), then Core1 cmd; hold core1_ready=0 → Core0 dispatched, halted stays 0 while core1_ready=0. Raise it → halted=1 next cycle, no start for HALT or the trailing Core1 cmd, cmd_ready=0, occupancy=1.
- Core leaves ready high permanently; push 4 Core0 cmds back-to-back → core0_start pulses spaced exactly 2 cycles apart, core0_count=4.
- Assert rst while occupancy=3 in DRAIN → next cycle all outputs 0, occupancy=0, state RUN, cmd_ready=1 after rst deasserts.
